// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states and the flush NOP.
package ifetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } if_state_e;

  localparam logic [31:0] IF_NOP = 32'h0000_0013;

endpackage

// File: rtl/ifetch_if.sv
// Bundle of icache and decode-side signals of the fetch stage; master = ifetch, slave = environment.
interface ifetch_if #(
  parameter int unsigned WIDTH = 32
);
  logic             o_mem_rq;
  logic             o_rnw;
  logic [WIDTH-1:0] o_pc;
  logic [WIDTH-1:0] i_inst_data;
  logic             o_valid;
  logic [WIDTH-1:0] o_inst;
  logic [WIDTH-1:0] o_inst_pc;
  logic             i_ready;
  logic             i_redirect;
  logic [WIDTH-1:0] i_redirect_pc;
  logic             i_halt;

  modport master (
    output o_mem_rq, o_rnw, o_pc, o_valid, o_inst, o_inst_pc,
    input  i_inst_data, i_ready, i_redirect, i_redirect_pc, i_halt
  );

  modport slave (
    input  o_mem_rq, o_rnw, o_pc, o_valid, o_inst, o_inst_pc,
    output i_inst_data, i_ready, i_redirect, i_redirect_pc, i_halt
  );
endinterface

// File: rtl/ifetch_fetch_queue.sv
// In-order {pc, inst} queue between icache and decode; supports same-cycle push+pop and flush.
module fetch_queue
  import ifetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [2*WIDTH-1:0]         push_data,
  input  logic                       pop,
  output logic                       valid,
  output logic [2*WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Slot 0 becomes the head after a flush, so decode sees a NOP while the queue refills
      mem[0] <= {{WIDTH{1'b0}}, WIDTH'(IF_NOP)};
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign valid = (count != '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/ifetch.sv
// Fetch stage: owns the PC, issues one icache read per cycle and queues {pc, inst} for decode.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 2,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic     i_clk,
  input  logic     i_reset,
  ifetch_if.master bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  if_state_e            state;
  logic [WIDTH-1:0]     pc;
  logic [2*WIDTH-1:0]   head;
  logic [CW-1:0]        count;
  logic                 q_valid;
  logic                 space;
  logic                 issue;
  logic                 deq;
  logic                 flush;

  // A dequeue in the same cycle frees a slot, which keeps throughput at one per cycle
  assign space = (count < CW'(DEPTH)) | (q_valid & bus.i_ready);
  assign issue = !i_reset & (state == S_FETCH) & !bus.i_redirect & !bus.i_halt & space;
  assign deq   = q_valid & bus.i_ready & !bus.i_redirect;
  assign flush = bus.i_redirect;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
    end else if (bus.i_redirect) begin
      state <= S_FETCH;
      pc    <= {bus.i_redirect_pc[WIDTH-1:2], 2'b00};
    end else begin
      case (state)
        S_IDLE:  state <= S_FETCH;
        S_FETCH: begin
          if (bus.i_halt) state <= S_HALT;
          else if (issue) pc <= pc + WIDTH'(4);
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  fetch_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_queue (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .flush     (flush),
    .push      (issue),
    .push_data ({pc, bus.i_inst_data}),
    .pop       (deq),
    .valid     (q_valid),
    .head      (head),
    .count     (count)
  );

  assign bus.o_mem_rq  = issue;
  assign bus.o_rnw     = 1'b1;
  assign bus.o_pc      = pc;
  assign bus.o_valid   = q_valid;
  assign bus.o_inst    = head[WIDTH-1:0];
  assign bus.o_inst_pc = head[2*WIDTH-1:WIDTH];

endmodule
